// File: rtl/sd_spi_engine.sv
// Command-driven SPI mode-0 master for the SD card path, with a first-word
// fall-through receive FIFO and selectable slow/fast clock dividers.
`timescale 1ns/1ps
module sd_spi_engine #(
  parameter int unsigned SLOW_DIV   = 30,
  parameter int unsigned FAST_DIV   = 1,
  parameter int unsigned DIV_W      = 5,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 10
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        CMD_VALID,
  input  logic [2:0]                  CMD_OP,
  input  logic [7:0]                  CMD_DATA,
  input  logic [LEN_W-1:0]            CMD_LEN,
  output logic                        CMD_READY,
  output logic                        BUSY,
  output logic                        HIGH_SPEED,
  output logic [7:0]                  RX_DATA,
  output logic                        RX_VALID,
  input  logic                        RX_POP,
  output logic [$clog2(FIFO_DEPTH):0] RX_COUNT,
  output logic                        SPI_CLK,
  output logic                        SPI_MOSI,
  output logic                        SPI_CS,
  input  logic                        SPI_MISO
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL = FIFO_DEPTH[PTR_W:0];
  localparam logic [DIV_W-1:0] SLOW = SLOW_DIV[DIV_W-1:0];
  localparam logic [DIV_W-1:0] FAST = FAST_DIV[DIV_W-1:0];

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, SHIFT, NEXT} state_t;
  typedef enum logic [2:0] {
    OP_XFER = 3'd0, OP_WRITE = 3'd1, OP_READ_BURST = 3'd2,
    OP_SET_CS = 3'd3, OP_SET_SPEED = 3'd4
  } op_t;
  typedef enum logic [1:0] {K_WRITE, K_XFER, K_BURST} kind_t;

  state_t             state, next_state;
  op_t                op;
  kind_t              kind;
  logic               cs, high_speed, spi_clk;
  logic [7:0]         tx_sh, rx_sh;
  logic [LEN_W-1:0]   remaining;
  logic [DIV_W-1:0]   div, div_cnt;
  logic [3:0]         half_cnt;
  logic               tick, byte_done, push, pop;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic [PTR_W:0]     count;

  assign op = op_t'(CMD_OP);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    tick       = 1'b0;
    byte_done  = 1'b0;
    CMD_READY  = 1'b0;
    SPI_MOSI   = tx_sh[7];
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        SPI_MOSI  = 1'b1;
        if (CMD_VALID) begin
          case (op)
            OP_XFER:       next_state = WAIT_SPACE;
            OP_WRITE:      next_state = SHIFT;
            OP_READ_BURST: if (CMD_LEN != '0) next_state = WAIT_SPACE;
            default: ;
          endcase
        end
      end
      WAIT_SPACE: if (count != FULL) next_state = SHIFT;
      SHIFT: begin
        if (div_cnt == div) begin
          tick = 1'b1;
          // Half 15 ends with the 8th falling SPI_CLK edge: the byte is complete.
          if (half_cnt == 4'd15) begin
            byte_done  = 1'b1;
            next_state = (kind == K_BURST) ? NEXT : IDLE;
          end
        end
      end
      NEXT:    next_state = (remaining == '0) ? IDLE : WAIT_SPACE;
      default: next_state = IDLE;
    endcase
    BUSY = ~CMD_READY;
  end

  assign push = byte_done && (kind != K_WRITE);
  assign pop  = RX_POP && (count != '0);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cs         <= 1'b1;
      high_speed <= 1'b0;
      spi_clk    <= 1'b0;
      tx_sh      <= '1;
      rx_sh      <= '0;
      kind       <= K_WRITE;
      remaining  <= '0;
      div        <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (CMD_VALID) begin
          div      <= high_speed ? FAST : SLOW;
          div_cnt  <= '0;
          half_cnt <= '0;
          spi_clk  <= 1'b0;
          case (op)
            OP_XFER:       begin tx_sh <= CMD_DATA; kind <= K_XFER;  end
            OP_WRITE:      begin tx_sh <= CMD_DATA; kind <= K_WRITE; end
            OP_READ_BURST: begin tx_sh <= '1; kind <= K_BURST; remaining <= CMD_LEN; end
            OP_SET_CS:     cs <= CMD_DATA[0];
            OP_SET_SPEED:  high_speed <= CMD_DATA[0];
            default: ;
          endcase
        end
        SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 4'd1;
            spi_clk  <= ~spi_clk;
            if (!spi_clk) rx_sh <= {rx_sh[6:0], SPI_MISO};
            else          tx_sh <= {tx_sh[6:0], 1'b1};
            if (byte_done && kind == K_BURST) remaining <= remaining - 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        NEXT: begin
          tx_sh    <= '1;
          div_cnt  <= '0;
          half_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push && !RESET) mem[wptr] <= rx_sh;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign RX_DATA    = (count != '0) ? mem[rptr] : '0;
  assign RX_VALID   = (count != '0);
  assign RX_COUNT   = count;
  assign SPI_CLK    = spi_clk;
  assign SPI_CS     = cs;
  assign HIGH_SPEED = high_speed;
endmodule

// File: tb/tb_sd_spi_engine.sv
// Directed bench for sd_spi_engine: a cycle-timeline model of the engine and
// FIFO is compared every clock, plus hand-computed checks per scenario.
`timescale 1ns/1ps
module tb_sd_spi_engine;
  localparam int SLOW_H = 31;
  localparam int FAST_H = 2;
  localparam int DEPTH  = 16;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic [2:0] CMD_OP = '0;
  logic [7:0] CMD_DATA = '0;
  logic [9:0] CMD_LEN = '0;
  logic       RX_POP = 1'b0;
  logic       SPI_MISO = 1'b1;
  logic       CMD_READY, BUSY, HIGH_SPEED, RX_VALID, SPI_CLK, SPI_MOSI, SPI_CS;
  logic [7:0] RX_DATA;
  logic [4:0] RX_COUNT;

  sd_spi_engine #(
    .SLOW_DIV(30), .FAST_DIV(1), .DIV_W(5), .FIFO_DEPTH(16), .LEN_W(10)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP),
    .CMD_DATA(CMD_DATA), .CMD_LEN(CMD_LEN), .CMD_READY(CMD_READY), .BUSY(BUSY),
    .HIGH_SPEED(HIGH_SPEED), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_POP(RX_POP),
    .RX_COUNT(RX_COUNT), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS),
    .SPI_MISO(SPI_MISO)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // SD card stand-in: shifts slave_bytes out MSB-first, changing after each falling SPI_CLK.
  logic [7:0] slave_bytes [64];
  int         falls, rises, edges, hi_cyc;
  logic       sclk_prev;
  logic [7:0] mosi_cap;
  logic [5:0] sb_idx;
  logic [2:0] sb_bit;

  always @(negedge CLOCK_50) begin
    if (RESET) begin
      falls = 0; rises = 0; edges = 0; hi_cyc = 0; sclk_prev = 1'b0; mosi_cap = '0;
    end else begin
      if (SPI_CLK != sclk_prev) edges++;
      if (sclk_prev && !SPI_CLK) falls++;
      if (!sclk_prev && SPI_CLK) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], SPI_MOSI};
      end
      if (SPI_CLK) hi_cyc++;
      sclk_prev = SPI_CLK;
    end
    sb_idx   = 6'(falls / 8);
    sb_bit   = 3'(7 - (falls % 8));
    SPI_MISO = slave_bytes[sb_idx][sb_bit];
  end

  // Reference model: m_t counts clocks since the byte started shifting.
  typedef enum {PH_IDLE, PH_WAIT, PH_RUN, PH_GAP} ph_t;
  ph_t        m_ph = PH_IDLE;
  bit         m_on = 1'b0;
  bit         m_cs, m_hs, m_push, m_burst, m_space;
  logic [7:0] m_tx;
  logic [7:0] m_q [$];
  int         m_t, m_H, m_left, m_bidx;

  always @(posedge CLOCK_50) begin
    if (RESET) begin
      m_on = 1'b1; m_cs = 1'b1; m_hs = 1'b0; m_q.delete();
      m_ph = PH_IDLE; m_bidx = 0; m_t = 0; m_left = 0; m_tx = 8'hFF;
    end else if (m_on) begin
      m_space = m_q.size() < DEPTH;
      if (RX_POP && m_q.size() > 0) void'(m_q.pop_front());
      case (m_ph)
        PH_IDLE: if (CMD_VALID) begin
          m_H = m_hs ? FAST_H : SLOW_H;
          case (CMD_OP)
            3'd0: begin m_tx = CMD_DATA; m_push = 1; m_burst = 0; m_ph = PH_WAIT; end
            3'd1: begin m_tx = CMD_DATA; m_push = 0; m_burst = 0; m_ph = PH_RUN; m_t = 0; end
            3'd2: if (CMD_LEN != 0) begin
              m_tx = 8'hFF; m_push = 1; m_burst = 1; m_left = int'(CMD_LEN) - 1; m_ph = PH_WAIT;
            end
            3'd3: m_cs = CMD_DATA[0];
            3'd4: m_hs = CMD_DATA[0];
            default: ;
          endcase
        end
        PH_WAIT: if (m_space) begin m_ph = PH_RUN; m_t = 0; end
        PH_RUN: begin
          m_t++;
          if (m_t == 16 * m_H) begin
            if (m_push) m_q.push_back(slave_bytes[6'(m_bidx)]);
            m_bidx++;
            m_ph = m_burst ? PH_GAP : PH_IDLE;
          end
        end
        PH_GAP: begin
          if (m_left == 0) m_ph = PH_IDLE;
          else begin m_left--; m_tx = 8'hFF; m_ph = PH_WAIT; end
        end
        default: ;
      endcase
    end
  end

  logic e_clk, e_mosi;
  always @(negedge CLOCK_50) begin
    if (m_on) begin
      e_clk = (m_ph == PH_RUN) && (((m_t / m_H) % 2) == 1);
      case (m_ph)
        PH_WAIT: e_mosi = m_tx[7];
        PH_RUN:  e_mosi = m_tx[3'(7 - m_t / (2 * m_H))];
        default: e_mosi = 1'b1;
      endcase
      chk("ready",    32'(CMD_READY),  32'(m_ph == PH_IDLE));
      chk("busy",     32'(BUSY),       32'(m_ph != PH_IDLE));
      chk("cs",       32'(SPI_CS),     32'(m_cs));
      chk("speed",    32'(HIGH_SPEED), 32'(m_hs));
      chk("spi_clk",  32'(SPI_CLK),    32'(e_clk));
      chk("mosi",     32'(SPI_MOSI),   32'(e_mosi));
      chk("rx_count", 32'(RX_COUNT),   32'(m_q.size()));
      chk("rx_valid", 32'(RX_VALID),   32'(m_q.size() > 0));
      chk("rx_data",  32'(RX_DATA),    32'((m_q.size() > 0) ? m_q[0] : 8'h00));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic do_reset();
    CMD_VALID = 1'b0; RX_POP = 1'b0; RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] data, input logic [9:0] len);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = data; CMD_LEN = len;
    tick();
    CMD_VALID = 1'b0;
  endtask

  // n counts clock edges from the accept edge up to the one that re-raises CMD_READY.
  task automatic wait_ready(input int budget, output int n);
    n = 1;
    while (!CMD_READY && n < budget) begin tick(); n++; end
    chk("ready_within_budget", 32'(CMD_READY), 32'd1);
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_head", 32'(RX_DATA), 32'(exp));
    RX_POP = 1'b1;
    tick();
    RX_POP = 1'b0;
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) slave_bytes[i] = 8'(i * 37 + 11);

    do_reset();
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_busy",  32'(BUSY),      32'd0);
    chk("rst_cs",    32'(SPI_CS),    32'd1);
    chk("rst_clk",   32'(SPI_CLK),   32'd0);
    chk("rst_mosi",  32'(SPI_MOSI),  32'd1);
    chk("rst_count", 32'(RX_COUNT),  32'd0);
    chk("rst_data",  32'(RX_DATA),   32'h00);

    // Slow XFER 0xA5 out, 0x3C in.
    slave_bytes[0] = 8'h3C;
    cmd(3'd0, 8'hA5, 10'd0);
    wait_ready(2000, n);
    chk("xfer_cycles", 32'(n),        32'd498);
    chk("xfer_pulses", 32'(rises),    32'd8);
    chk("xfer_high",   32'(hi_cyc),   32'd248);
    chk("xfer_mosi",   32'(mosi_cap), 32'hA5);
    chk("xfer_rx",     32'(RX_DATA),  32'h3C);
    chk("xfer_count",  32'(RX_COUNT), 32'd1);

    // Fast WRITE 0x40.
    do_reset();
    cmd(3'd4, 8'h01, 10'd0);
    chk("speed_on", 32'(HIGH_SPEED), 32'd1);
    cmd(3'd1, 8'h40, 10'd0);
    wait_ready(200, n);
    chk("write_cycles", 32'(n),        32'd33);
    chk("write_pulses", 32'(rises),    32'd8);
    chk("write_high",   32'(hi_cyc),   32'd16);
    chk("write_mosi",   32'(mosi_cap), 32'h40);
    chk("write_count",  32'(RX_COUNT), 32'd0);

    // Burst of 20 with back-pressure, a pop coinciding with a push, wrap-around.
    do_reset();
    cmd(3'd4, 8'h01, 10'd0);
    for (int i = 0; i < 20; i++) slave_bytes[i] = 8'(i);
    cmd(3'd2, 8'h00, 10'd20);
    n = 0;
    while (RX_COUNT != 5'd16 && n < 2000) begin tick(); n++; end
    chk("burst_fill", 32'(RX_COUNT), 32'd16);
    repeat (50) tick();
    chk("stall_count",  32'(RX_COUNT), 32'd16);
    chk("stall_clk",    32'(SPI_CLK),  32'd0);
    chk("stall_busy",   32'(BUSY),     32'd1);
    chk("stall_pulses", 32'(rises),    32'd128);
    pop_chk(8'd0);
    repeat (32) tick();
    pop_chk(8'd1);
    chk("pop_with_push_count", 32'(RX_COUNT), 32'd15);
    pop_chk(8'd2);
    pop_chk(8'd3);
    wait_ready(2000, n);
    chk("burst_end_count", 32'(RX_COUNT), 32'd16);
    for (int i = 4; i < 20; i++) pop_chk(8'(i));
    chk("drained", 32'(RX_VALID), 32'd0);

    // Chip select, zero-length burst, pop on empty.
    do_reset();
    cmd(3'd3, 8'h00, 10'd0);
    chk("cs_low", 32'(SPI_CS), 32'd0);
    cmd(3'd2, 8'h00, 10'd0);
    chk("len0_ready", 32'(CMD_READY), 32'd1);
    RX_POP = 1'b1;
    tick();
    RX_POP = 1'b0;
    repeat (20) tick();
    chk("len0_pulses", 32'(rises),    32'd0);
    chk("empty_pop",   32'(RX_COUNT), 32'd0);
    cmd(3'd3, 8'h01, 10'd0);
    chk("cs_high", 32'(SPI_CS), 32'd1);

    // Reset in the middle of a byte.
    do_reset();
    cmd(3'd4, 8'h01, 10'd0);
    cmd(3'd3, 8'h00, 10'd0);
    cmd(3'd0, 8'h5A, 10'd0);
    n = 0;
    while (edges < 5 && n < 200) begin tick(); n++; end
    chk("midbyte_reached", 32'(edges >= 5), 32'd1);
    RESET = 1'b1;
    tick();
    chk("abort_clk",   32'(SPI_CLK),    32'd0);
    chk("abort_cs",    32'(SPI_CS),     32'd1);
    chk("abort_mosi",  32'(SPI_MOSI),   32'd1);
    chk("abort_count", 32'(RX_COUNT),   32'd0);
    chk("abort_ready", 32'(CMD_READY),  32'd1);
    chk("abort_speed", 32'(HIGH_SPEED), 32'd0);
    RESET = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
